// File: rtl/full_st0_feed_tx.sv
// Transmit-side feeder for the fully-connected stage 0 input port.
// Reads vectors from a single-port memory (1-cycle read latency) and streams
// them as element bursts through a 2-entry credit-controlled FIFO, so a
// continuously ready consumer receives one element per cycle.
module full_st0_feed_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   vec_length,
    input  logic [7:0]            vec_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] stage_0_data,
    output logic                  stage_0_data_vld,
    output logic                  stage_0_data_fst,
    input  logic                  stage_0_data_rdy,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

    localparam logic [ADDR_WIDTH:0]   LenOne  = 1;
    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    state_e state_q, state_d;

    // Job parameters latched on an accepted start
    logic [ADDR_WIDTH:0]   len_q;
    logic [7:0]            cnt_q;

    // Read sequencing counters and running address
    logic [ADDR_WIDTH:0]   elem_q;
    logic [7:0]            vec_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // One-deep read pipeline: a read issued last cycle returns data this cycle
    logic                  in_flight_q;
    logic                  fst_pipe_q;

    // 2-entry FIFO
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_fst_q  [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            occ_q;

    logic       push;
    logic       pop;
    logic       vld;
    logic [2:0] credit_sum;
    logic       credit_ok;
    logic       last_elem;
    logic       last_vec;
    logic       issue;
    logic       last_issue;
    logic       accept;

    // Datapath handshakes, credit check and end-of-job detection
    always_comb begin
        vld        = (occ_q != 2'd0);
        pop        = vld & stage_0_data_rdy;
        push       = in_flight_q;
        // Occupancy the FIFO will need once everything outstanding lands,
        // counting the slot freed by a pop in this same cycle.
        credit_sum = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
        credit_ok  = (credit_sum < 3'd2);
        last_elem  = (elem_q == (len_q - LenOne));
        last_vec   = (vec_q == (cnt_q - 8'd1));
        issue      = (state_q == StRun) && credit_ok;
        last_issue = issue && last_elem && last_vec;
        accept     = (state_q == StIdle) && start;
    end

    // Next-state logic and control outputs
    always_comb begin
        state_d   = state_q;
        mem_rd_en = issue;
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StFinish);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if ((vec_length == '0) || (vec_count == 8'd0)) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Last element leaves when nothing else is buffered or in flight
                if (pop && (occ_q == 2'd1) && !in_flight_q) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Job parameter capture and read counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            cnt_q  <= '0;
            elem_q <= '0;
            vec_q  <= '0;
            addr_q <= '0;
        end else if (accept) begin
            len_q  <= vec_length;
            cnt_q  <= vec_count;
            elem_q <= '0;
            vec_q  <= '0;
            addr_q <= base_addr;
        end else if (issue) begin
            // Address wraps naturally at 2^ADDR_WIDTH
            addr_q <= addr_q + AddrOne;
            if (last_elem) begin
                elem_q <= '0;
                vec_q  <= vec_q + 8'd1;
            end else begin
                elem_q <= elem_q + LenOne;
            end
        end
    end

    // Read pipeline: fst is decided at issue time and travels with the read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight_q <= 1'b0;
            fst_pipe_q  <= 1'b0;
        end else begin
            in_flight_q <= issue;
            fst_pipe_q  <= issue && (elem_q == '0);
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_fst_q[i]  <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_rd_data;
                fifo_fst_q[wr_ptr_q]  <= fst_pipe_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Stream outputs come straight from the FIFO head
    always_comb begin
        mem_rd_addr      = addr_q;
        stage_0_data_vld = vld;
        stage_0_data     = fifo_data_q[rd_ptr_q];
        stage_0_data_fst = fifo_fst_q[rd_ptr_q] & vld;
    end

endmodule

// File: tb/tb_full_st0_feed_tx.sv
// Scoreboard bench for full_st0_feed_tx: jobs push their expected element
// stream into a queue; an independent monitor pops and compares on each
// transfer and checks read addresses, credit, stall stability and timing.
module tb_full_st0_feed_tx;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int MEM_SIZE = 64;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   vec_length;
    logic [7:0]    vec_count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] stage_0_data;
    logic          stage_0_data_vld;
    logic          stage_0_data_fst;
    logic          stage_0_data_rdy;
    logic          busy;
    logic          done;

    full_st0_feed_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .vec_length       (vec_length),
        .vec_count        (vec_count),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .stage_0_data     (stage_0_data),
        .stage_0_data_vld (stage_0_data_vld),
        .stage_0_data_fst (stage_0_data_fst),
        .stage_0_data_rdy (stage_0_data_rdy),
        .busy             (busy),
        .done             (done)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          f;
    } elem_t;

    logic [DW-1:0] mem [MEM_SIZE];
    elem_t         exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int job_base = 0;
    int rd_count, xfer_count, vld_count, done_count;
    int done_rel, first_vld_rel, last_xfer_rel;
    int rdy_mode = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_fst = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data valid one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready generator
    initial begin
        int phase = 0;
        stage_0_data_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    stage_0_data_rdy = (phase % 3 == 0);
                    phase++;
                end
                2: stage_0_data_rdy = 1'($urandom % 2);
                default: stage_0_data_rdy = 1'b1;
            endcase
        end
    end

    // Monitor: compares DUT activity against the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", 32'(stage_0_data_vld), 1);
                chk("stall_data", stage_0_data, prev_data);
                chk("stall_fst", 32'(stage_0_data_fst), 32'(prev_fst));
            end
            if (mem_rd_en) begin
                int popnow;
                popnow = (stage_0_data_vld && stage_0_data_rdy) ? 1 : 0;
                chk("credit", 32'((rd_count - xfer_count - popnow) < 2), 1);
                chk("rd_addr", 32'(mem_rd_addr), 32'((job_base + rd_count) % MEM_SIZE));
                rd_count++;
            end
            if (stage_0_data_vld) vld_count++;
            if (stage_0_data_vld && stage_0_data_rdy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_elem: got data %0h with nothing expected",
                             stage_0_data);
                end else begin
                    elem_t e;
                    e = exp_q.pop_front();
                    chk("data", stage_0_data, e.d);
                    chk("fst", 32'(stage_0_data_fst), 32'(e.f));
                end
                if (xfer_count == 0) first_vld_rel = cyc - start_cyc;
                last_xfer_rel = cyc - start_cyc;
                xfer_count++;
            end
            if (done) begin
                done_count++;
                done_rel = cyc - start_cyc;
                chk("busy_at_done", 32'(busy), 0);
            end
            prev_stall = stage_0_data_vld && !stage_0_data_rdy;
            prev_data  = stage_0_data;
            prev_fst   = stage_0_data_fst;
        end
    end

    task automatic clear_job_stats();
        rd_count = 0;
        xfer_count = 0;
        vld_count = 0;
        done_count = 0;
        done_rel = -1;
        first_vld_rel = -1;
        last_xfer_rel = -1;
    endtask

    task automatic pulse_start(input int base, input int len, input int cnt);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(base);
        vec_length = (AW + 1)'(len);
        vec_count = 8'(cnt);
        start_cyc = cyc;
    endtask

    // Run one job; restart_at > 0 pulses a second start that many cycles in
    task automatic run_job(input int base, input int len, input int cnt, input int mode,
                           input bit timing, input int restart_at);
        int total;
        int budget;
        total = len * cnt;
        budget = total * 8 + 20;
        clear_job_stats();
        job_base = base;
        for (int i = 0; i < total; i++) begin
            elem_t e;
            e.d = mem[(base + i) % MEM_SIZE];
            e.f = ((i % len) == 0);
            exp_q.push_back(e);
        end
        rdy_mode = mode;
        pulse_start(base, len, cnt);
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            start = (k == restart_at);
            if (k == restart_at) begin
                base_addr = AW'(base + 17);
                vec_length = 7'd2;
                vec_count = 8'd3;
            end
            if (done_count > 0) break;
        end
        start = 1'b0;
        if (done_count == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done within %0d cycles (base %0d L %0d V %0d)",
                     budget, base, len, cnt);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", 32'(done_count), 1);
        chk("rd_count", 32'(rd_count), 32'(total));
        chk("xfer_count", 32'(xfer_count), 32'(total));
        chk("queue_empty", 32'(exp_q.size()), 0);
        if (timing) begin
            if (total > 0) begin
                chk("first_vld_cycle", 32'(first_vld_rel), 3);
                chk("last_xfer_cycle", 32'(last_xfer_rel), 32'(total + 2));
                chk("done_cycle", 32'(done_rel), 32'(total + 3));
            end else begin
                chk("zero_done_cycle", 32'(done_rel), 1);
                chk("zero_vld", 32'(vld_count), 0);
            end
        end
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 0);
        chk({tag, "_data"}, stage_0_data, 0);
        chk({tag, "_vld"}, 32'(stage_0_data_vld), 0);
        chk({tag, "_fst"}, 32'(stage_0_data_fst), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        vec_length = '0;
        vec_count = '0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'(i);
        clear_job_stats();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic transfer, then backpressure on the same job
        run_job(0, 4, 2, 0, 1'b1, 0);
        run_job(0, 4, 2, 1, 1'b0, 0);
        // Address wrap-around
        run_job(62, 3, 1, 0, 1'b1, 0);
        // Zero-length jobs
        run_job(0, 0, 5, 0, 1'b1, 0);
        run_job(0, 5, 0, 0, 1'b1, 0);
        // Start while busy must be ignored
        run_job(0, 4, 2, 0, 1'b1, 4);

        // Reset mid-transfer
        clear_job_stats();
        job_base = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({mem[i], 1'(i == 0)});
        rdy_mode = 0;
        pulse_start(0, 8, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc - start_cyc < 5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'hA000_0000 | 32'(i);
        run_job(10, 4, 1, 0, 1'b1, 0);

        // Randomized jobs against random backpressure
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
            run_job(int'($urandom_range(0, 63)), int'($urandom_range(1, 12)),
                    int'($urandom_range(1, 4)), 2, 1'b0, 0);
        end
        run_job(5, 64, 2, 2, 1'b0, 0);
        run_job(33, 7, 3, 0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/full_st0_feed_tx.md
# full_st0_feed_tx

Transmit-side feeder for a fully-connected stage input port. It reads input vectors from a local single-port memory and drives the `stage_0_data` / `stage_0_data_fst` / `stage_0_data_vld` / `stage_0_data_rdy` stream that the stage controller consumes. Each vector is emitted as a burst of elements, with `fst` marking element 0. The block absorbs memory read latency with a small credit-controlled FIFO, so it sustains one element per cycle under continuous `rdy`.

## Interface
- `DATA_WIDTH`, 32, element width (packed float_24_8).
- `ADDR_WIDTH`, 6, memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that launches a transfer; accepted only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first memory address; sampled on an accepted `start`.
- `vec_length`  in  ADDR_WIDTH+1  elements per vector, 0..64; sampled on `start`.
- `vec_count`  in  8  number of vectors, 0..255; sampled on `start`.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_rd_addr`  out  ADDR_WIDTH  memory read address.
- `mem_rd_data`  in  DATA_WIDTH  read data; valid exactly 1 cycle after `mem_rd_en`.
- `stage_0_data`  out  DATA_WIDTH  stream element (FIFO head).
- `stage_0_data_vld`  out  1  element valid.
- `stage_0_data_fst`  out  1  element is index 0 of a vector; qualified by `vld`.
- `stage_0_data_rdy`  in  1  consumer ready; transfer = `vld` & `rdy`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at the end of a transfer.

## Operation
- States:
  - IDLE --start--> RUN (or --> FINISH if `vec_length`==0 or `vec_count`==0).
  - RUN --last read issued--> DRAIN.
  - DRAIN --last element transferred--> FINISH.
  - FINISH --> IDLE.
- `start` is ignored outside IDLE.
- Read sequencing:
  - Read counters are `elem_idx` (0..vec_length-1) and `vec_idx` (0..vec_count-1).
  - `mem_rd_addr` = base_addr + vec_idx*vec_length + elem_idx, truncated to ADDR_WIDTH.
  - Running address increments by 1 per issued read and wraps silently from 2^ADDR_WIDTH-1 to 0.
- FIFO:
  - 2 entries, each {data, fst}.
  - The fst bit is computed at issue time (`elem_idx`==0) and carried through a 1-cycle pipeline alongside the read.
- Credit rule: issue a read in a RUN cycle only when occupancy + in_flight − pop_this_cycle < 2. The FIFO can never overflow.
- Push happens the cycle `mem_rd_data` is valid. Simultaneous push and pop on a full FIFO is legal and leaves occupancy unchanged.
- Outputs:
  - `stage_0_data_vld` = FIFO non-empty.
  - `stage_0_data` and `stage_0_data_fst` come from the head entry and stay stable while `vld` & !`rdy`.
- `busy` is high in RUN and DRAIN. `done` is high only in FINISH.
- Zero-length job: no reads, no `vld`, and `done` pulses in the cycle after `start`.
- `reset` asserted mid-transfer:
  - State returns to IDLE, FIFO and in-flight read are flushed, and counters clear.
  - The pending memory return is discarded.

## Timing
- Reset values: `mem_rd_en`=0, `mem_rd_addr`=0, `stage_0_data`=0, `stage_0_data_vld`=0, `stage_0_data_fst`=0, `busy`=0, `done`=0.
- Latency with `start` in cycle 0:
  - First `mem_rd_en` in cycle 1.
  - Data returns in cycle 2.
  - First `stage_0_data_vld` in cycle 3.
- With `rdy` held high, one element transfers per cycle from cycle 3 with no bubbles, including across vector boundaries.
- Total of L*V elements: last transfer in cycle L*V+2.
- `done` pulses in the cycle after the last transfer; `busy` falls in the same cycle `done` rises.
- Backpressure: `rdy` low stalls reads within 1 cycle per the credit rule. `vld` never drops without a transfer.

## Test plan
- Basic transfer:
  - Stimulus: memory[i]=i, base 0, L=4, V=2, `rdy`=1.
  - Response: `vld` cycles 3–10 with data 0..7; `fst` on data 0 and 4; `done` in cycle 11; exactly 8 `mem_rd_en`.
- Backpressure:
  - Stimulus: same job, `rdy` toggling 1,0,0,1,...
  - Response: data order 0..7 with no loss or duplication; data and `fst` stable across stall cycles; never more than 2 outstanding (FIFO + in-flight).
- Wrap-around:
  - Stimulus: base 62, L=3, V=1.
  - Response: read addresses 62, 63, 0; data memory[62], memory[63], memory[0].
- Zero length:
  - Stimulus: L=0, V=5 (and separately L=5, V=0).
  - Response: no `mem_rd_en`; `done` in cycle 1; `vld` stays 0.
- Start while busy:
  - Stimulus: second `start` pulse mid-transfer.
  - Response: ignored; single `done`; element count unchanged.
- Reset mid-transfer:
  - Stimulus: `reset` low in cycle 5 of an L=8, V=1 job, then a fresh job.
  - Response: all outputs 0 on the next evaluation; fresh job output starts with element 0 and `fst`=1; no stale elements.
